// File: rtl/folding_fir_filter.sv
// 8-tap signed FIR filter folded by 4: two multipliers are time-shared over a
// four-phase schedule, giving one saturated 20-bit result per 10-bit input sample.
module folding_fir_filter #(
  parameter logic signed [9:0] C0 = 10'sd1,
  parameter logic signed [9:0] C1 = 10'sd2,
  parameter logic signed [9:0] C2 = 10'sd3,
  parameter logic signed [9:0] C3 = 10'sd4,
  parameter logic signed [9:0] C4 = 10'sd4,
  parameter logic signed [9:0] C5 = 10'sd3,
  parameter logic signed [9:0] C6 = 10'sd2,
  parameter logic signed [9:0] C7 = 10'sd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [9:0]  din,
  output logic               wd,
  output logic signed [19:0] dout
);

  localparam logic signed [22:0] SAT_MAX = 23'sd524287;
  localparam logic signed [22:0] SAT_MIN = -23'sd524288;

  logic [1:0]         ph;
  logic signed [9:0]  x [8];
  logic signed [22:0] acc;
  logic signed [19:0] prod [2];
  logic signed [22:0] p_sum;
  logic signed [22:0] acc_sum;
  logic signed [19:0] sat_val;

  function automatic logic signed [9:0] coef(input logic [2:0] k);
    logic signed [9:0] c;
    case (k)
      3'd0:    c = C0;
      3'd1:    c = C1;
      3'd2:    c = C2;
      3'd3:    c = C3;
      3'd4:    c = C4;
      3'd5:    c = C5;
      3'd6:    c = C6;
      default: c = C7;
    endcase
    return c;
  endfunction

  // Multiplier 0 serves taps 0..3, multiplier 1 serves taps 4..7; phase picks the pair.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mac
      localparam logic [2:0] BASE = 3'(gi * 4);
      logic [2:0]         tap;
      logic signed [9:0]  xs;
      logic signed [9:0]  cs;
      logic signed [19:0] xe;
      logic signed [19:0] ce;

      assign tap      = BASE + {1'b0, ph};
      assign xs       = x[tap];
      assign cs       = coef(tap);
      assign xe       = {{10{xs[9]}}, xs};
      assign ce       = {{10{cs[9]}}, cs};
      assign prod[gi] = xe * ce;
    end
  endgenerate

  assign p_sum   = {{3{prod[0][19]}}, prod[0]} + {{3{prod[1][19]}}, prod[1]};
  assign acc_sum = acc + p_sum;

  always_comb begin
    sat_val = acc_sum[19:0];
    if (acc_sum > SAT_MAX)
      sat_val = SAT_MAX[19:0];
    else if (acc_sum < SAT_MIN)
      sat_val = SAT_MIN[19:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph   <= 2'd0;
      acc  <= '0;
      dout <= '0;
      wd   <= 1'b0;
      for (int k = 0; k < 8; k++)
        x[k] <= '0;
    end else begin
      ph <= ph + 2'd1;
      wd <= 1'b0;
      case (ph)
        2'd0: acc <= p_sum;
        2'd1,
        2'd2: acc <= acc_sum;
        default: begin
          // Products above use the pre-shift delay line, so din joins the next output.
          acc  <= acc_sum;
          dout <= sat_val;
          wd   <= 1'b1;
          for (int k = 7; k > 0; k--)
            x[k] <= x[k-1];
          x[0] <= din;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_folding_fir_filter.sv
// Randomised and directed bench for folding_fir_filter: a default-coefficient
// instance and an all -512 instance, both compared against a sample-level model.
module tb_folding_fir_filter;

  logic               clk;
  logic               rst;
  logic signed [9:0]  din;
  logic               wd_d;
  logic signed [19:0] dout_d;
  logic               wd_s;
  logic signed [19:0] dout_s;

  folding_fir_filter u_dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .wd   (wd_d),
    .dout (dout_d)
  );

  folding_fir_filter #(
    .C0(-10'sd512), .C1(-10'sd512), .C2(-10'sd512), .C3(-10'sd512),
    .C4(-10'sd512), .C5(-10'sd512), .C6(-10'sd512), .C7(-10'sd512)
  ) u_sat (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .wd   (wd_s),
    .dout (dout_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  int coef_d [8] = '{1, 2, 3, 4, 4, 3, 2, 1};
  int hist [8];
  int edge_cnt;
  int exp_d;
  int exp_s;
  int res_q [$];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat20(input int v);
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  function automatic int model_y(input bit all_neg);
    int s = 0;
    for (int k = 0; k < 8; k++)
      s += (all_neg ? -512 : coef_d[k]) * hist[k];
    return sat20(s);
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 8; k++) hist[k] = 0;
    edge_cnt = 0;
    exp_d = 0;
    exp_s = 0;
    res_q.delete();
  endfunction

  // Called at a falling edge; drives din, advances one rising edge and checks.
  task automatic step(input int v);
    bit cap;
    din = 10'(v);
    @(posedge clk);
    #1;
    edge_cnt++;
    cap = (edge_cnt % 4 == 0);
    if (cap) begin
      exp_d = model_y(1'b0);
      exp_s = model_y(1'b1);
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = v;
      res_q.push_back(int'(dout_d));
    end
    check("wd", int'(wd_d), int'(cap));
    check("dout", int'(dout_d), exp_d);
    check("wd_sat", int'(wd_s), int'(cap));
    check("dout_sat", int'(dout_s), exp_s);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_dout", int'(dout_d), 0);
    check("rst_wd", int'(wd_d), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  int imp_tab [10] = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0};
  int stp_tab [10] = '{0, 100, 300, 600, 1000, 1400, 1700, 1900, 2000, 2000};

  initial begin
    rst = 1'b0;
    din = '0;
    model_clear();
    #12;
    check("init_dout", int'(dout_d), 0);
    check("init_wd", int'(wd_d), 0);
    @(negedge clk);
    rst = 1'b1;

    // Impulse at the first capture edge.
    for (int i = 1; i <= 44; i++) step((i == 4) ? 1 : 0);
    for (int i = 0; i < 10; i++) check($sformatf("impulse[%0d]", i), res_q[i], imp_tab[i]);

    // Step of 100.
    do_reset();
    for (int i = 0; i < 48; i++) step(100);
    for (int i = 0; i < 10; i++) check($sformatf("step[%0d]", i), res_q[i], stp_tab[i]);

    // Negative full scale: -10240 normally, +saturation on the all -512 instance.
    for (int i = 0; i < 40; i++) step(-512);
    check("negfs", int'(dout_d), -10240);
    check("sat_pos", int'(dout_s), 524287);

    for (int i = 0; i < 40; i++) step(511);
    check("posfs", int'(dout_d), 10220);
    check("sat_neg", int'(dout_s), -524288);

    // Random samples changing every clock; only capture-edge values matter.
    for (int i = 0; i < 240; i++) step($signed(10'($urandom)));

    // Asynchronous reset while ph==2, then first strobe 4 edges after release.
    while (edge_cnt % 4 != 2) step($signed(10'($urandom)));
    do_reset();
    check("mid_hist_dout", int'(dout_d), 0);
    for (int i = 0; i < 3; i++) step($signed(10'($urandom)));
    step(7);
    check("mid_first_wd", int'(wd_d), 1);
    check("mid_first_dout", int'(dout_d), 0);
    for (int i = 0; i < 40; i++) step($signed(10'($urandom)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
